// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing dot-product engine.
// Contents: RNG mode selectors, run FSM state encoding, W-bit reversal,
// maximal-length LFSR tap masks indexed by W, and the accumulator width.
package sc_pkg;

    localparam int RNG_CNT  = 0;   // counter / bit-reversed counter (exact)
    localparam int RNG_LFSR = 1;   // pair of Fibonacci LFSRs (approximate)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reverse the low w bits of v; bits at or above w come back as zero.
    function automatic logic [7:0] bitrev(input logic [7:0] v, input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

    // Feedback mask for a left-shifting Fibonacci LFSR: new LSB = ^(state & mask).
    // Each mask corresponds to a primitive polynomial, so the period is 2^w-1.
    function automatic logic [7:0] lfsr_taps(input int w);
        case (w)
            4:       return 8'h0C;
            5:       return 8'h14;
            6:       return 8'h30;
            7:       return 8'h60;
            default: return 8'hB8;
        endcase
    endfunction

    // Wide enough to hold n full-length streams of all ones.
    function automatic int acc_width(input int n, input int w);
        return $clog2(n * (1 << w) + 1);
    endfunction

endpackage

// File: rtl/sc_sng.sv
// Stochastic number generator: one unsigned comparator turning a binary
// operand into a unipolar stream bit against a per-cycle random value.
// Ports: value (operand), rnd (random value), bit_out (value > rnd).
module sc_sng #(
    parameter int W = 6
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] rnd,
    output logic         bit_out
);

    assign bit_out = (value > rnd);

endmodule

// File: rtl/sc_dot_engine.sv
// Stochastic-computing dot-product engine. N_TERMS activations are shared by
// N_CH weight sets; each pair is multiplied by ANDing their streams and the
// ones are counted per channel over one 2^W-cycle run.
// Ports: clk, rst (async, active high), en_in (start pulse), x_in / w_in
// (packed operands), busy (run in progress), en_out (one-cycle result valid),
// result (packed per-channel counts, held until the next completion).
//
// state | meaning
// IDLE  | waiting for en_in
// RUN   | streaming 2^W cycles, accumulating products
// DONE  | result just updated, en_out high; en_in here restarts immediately
module sc_dot_engine
    import sc_pkg::*;
#(
    parameter int W        = 6,
    parameter int N_TERMS  = 4,
    parameter int N_CH     = 2,
    parameter int RNG_MODE = 0,
    parameter int SEED_X   = 1,
    parameter int SEED_W   = 5
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       en_in,
    input  logic [N_TERMS*W-1:0]                       x_in,
    input  logic [N_CH*N_TERMS*W-1:0]                  w_in,
    output logic                                       busy,
    output logic                                       en_out,
    output logic [N_CH*acc_width(N_TERMS, W)-1:0]      result
);

    localparam int ACC_W = acc_width(N_TERMS, W);
    localparam int PS_W  = $clog2(N_TERMS + 1);
    localparam int NP    = N_CH * N_TERMS;

    state_t               state, state_nx;
    logic                 start;
    logic                 last;
    logic [W-1:0]         cnt;
    logic [N_TERMS*W-1:0] x_reg;
    logic [NP*W-1:0]      w_reg;
    logic [W-1:0]         rx, rw;
    logic [N_TERMS-1:0]   sx;
    logic [NP-1:0]        sw;
    logic [ACC_W-1:0]     acc  [N_CH];
    logic [PS_W-1:0]      psum [N_CH];

    assign start = en_in && (state == IDLE || state == DONE);
    assign last  = (cnt == {W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en_in) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = en_in ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        en_out = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            x_reg  <= '0;
            w_reg  <= '0;
            result <= '0;
            for (int c = 0; c < N_CH; c++) acc[c] <= '0;
        end else if (start) begin
            cnt   <= '0;
            x_reg <= x_in;
            w_reg <= w_in;
            for (int c = 0; c < N_CH; c++) acc[c] <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                acc[c] <= acc[c] + ACC_W'(psum[c]);
                // Final cycle's products go straight into result, not via acc.
                if (last) result[c*ACC_W +: ACC_W] <= acc[c] + ACC_W'(psum[c]);
            end
        end
    end

    generate
        if (RNG_MODE == RNG_LFSR) begin : g_lfsr
            localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));
            logic [W-1:0] lx, lw;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lx <= W'(SEED_X);
                    lw <= W'(SEED_W);
                end else if (start) begin
                    lx <= W'(SEED_X);
                    lw <= W'(SEED_W);
                end else if (state == RUN) begin
                    lx <= {lx[W-2:0], ^(lx & TAPS)};
                    lw <= {lw[W-2:0], ^(lw & TAPS)};
                end
            end

            assign rx = lx;
            assign rw = lw;
        end else begin : g_cnt
            // Bit reversal decorrelates the weight stream from the activation
            // stream so power-of-two operands multiply exactly.
            assign rx = cnt;
            assign rw = W'(bitrev(8'(cnt), W));
        end
    endgenerate

    for (genvar k = 0; k < N_TERMS; k++) begin : g_sx
        sc_sng #(.W(W)) u_sng (.value(x_reg[k*W +: W]), .rnd(rx), .bit_out(sx[k]));
    end

    for (genvar j = 0; j < NP; j++) begin : g_sw
        sc_sng #(.W(W)) u_sng (.value(w_reg[j*W +: W]), .rnd(rw), .bit_out(sw[j]));
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            psum[c] = '0;
            for (int k = 0; k < N_TERMS; k++) begin
                psum[c] = psum[c] + PS_W'(sx[k] & sw[c*N_TERMS + k]);
            end
        end
    end

endmodule

// File: tb/tb_sc_dot_engine.sv
module tb_sc_dot_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic [23:0] x_in;
    logic [47:0] w_in;
    logic        busy, en_out;
    logic [17:0] result;

    logic        en_l;
    logic [23:0] x_l;
    logic [47:0] w_l;
    logic        busy_l, eo_l;
    logic [17:0] res_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sc_dot_engine dut (
        .clk(clk), .rst(rst), .en_in(en_in), .x_in(x_in), .w_in(w_in),
        .busy(busy), .en_out(en_out), .result(result)
    );

    sc_dot_engine #(.RNG_MODE(1)) dut_l (
        .clk(clk), .rst(rst), .en_in(en_l), .x_in(x_l), .w_in(w_l),
        .busy(busy_l), .en_out(eo_l), .result(res_l)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] xv(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    // Mode-0 golden model: rx = t, rw = 6-bit reversal of t.
    function automatic int model(input logic [23:0] x, input logic [23:0] wc);
        int sum;
        logic [5:0] t6, r6;
        sum = 0;
        for (int t = 0; t < 64; t++) begin
            t6 = 6'(t);
            for (int i = 0; i < 6; i++) r6[i] = t6[5-i];
            for (int k = 0; k < 4; k++) begin
                if ((x[k*6 +: 6] > t6) && (wc[k*6 +: 6] > r6)) sum++;
            end
        end
        return sum;
    endfunction

    // Start a mode-0 run from IDLE; optionally pulse en_in at RUN cycle pulse_at.
    task automatic run0(input logic [23:0] x, input logic [47:0] w, input int pulse_at,
                        output int lat);
        @(negedge clk);
        x_in = x; w_in = w; en_in = 1'b1;
        @(posedge clk); #1;
        en_in = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            en_in = (n == pulse_at);
            if (en_out) begin
                lat = n;
                break;
            end
        end
        en_in = 1'b0;
    endtask

    task automatic run1(input logic [23:0] x, input logic [47:0] w, output int lat);
        @(negedge clk);
        x_l = x; w_l = w; en_l = 1'b1;
        @(posedge clk); #1;
        en_l = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (eo_l) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, t1, t2, pulses, diff;
        logic [17:0] first_l;
        logic [23:0] xa, w0, w1;

        rst = 1'b1; en_in = 1'b0; x_in = '0; w_in = '0;
        en_l = 1'b0; x_l = '0; w_l = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_en_out", en_out, 0);
        check("reset_result", result, 0);
        @(negedge clk); rst = 1'b0;

        // 1: full-scale operands
        xa = xv(63, 63, 63, 63);
        run0(xa, {xa, xa}, 0, lat);
        check("t1_latency", lat, 64);
        check("t1_res0", result[8:0], 252);
        check("t1_res1", result[17:9], 252);
        @(posedge clk); #1;
        check("t1_idle_after", busy, 0);

        // 2: half-scale, with an en_in pulse mid-run that must be ignored
        xa = xv(32, 32, 32, 32);
        run0(xa, {xa, xa}, 20, lat);
        check("t2_latency_pulse", lat, 64);
        check("t2_res0", result[8:0], 64);
        check("t2_res1", result[17:9], 64);
        @(posedge clk); #1;
        check("t2_no_queue", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t2_result_held", result[8:0], 64);

        xa = xv(0, 0, 0, 0);
        run0(xa, {xv(63, 17, 40, 5), xv(63, 63, 63, 63)}, 0, lat);
        check("t2_zero_res0", result[8:0], 0);
        check("t2_zero_res1", result[17:9], 0);

        // 3: mixed operands against the model and hand values
        xa = xv(63, 32, 0, 16);
        w0 = xv(63, 63, 63, 63);
        w1 = xv(32, 32, 32, 32);
        run0(xa, {w1, w0}, 0, lat);
        check("t3_res0_hand", result[8:0], 111);
        check("t3_res1_hand", result[17:9], 56);
        check("t3_res0_model", result[8:0], model(xa, w0));
        check("t3_res1_model", result[17:9], model(xa, w1));

        xa = xv(7, 50, 21, 63);
        w0 = xv(12, 3, 60, 44);
        w1 = xv(1, 33, 8, 62);
        run0(xa, {w1, w0}, 0, lat);
        check("t3b_res0_model", result[8:0], model(xa, w0));
        check("t3b_res1_model", result[17:9], model(xa, w1));

        // 4: reset during RUN aborts the run
        @(negedge clk);
        xa = xv(63, 63, 63, 63);
        x_in = xa; w_in = {xa, xa}; en_in = 1'b1;
        @(posedge clk); #1;
        en_in = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("t4_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("t4_busy_rst", busy, 0);
        check("t4_result_rst", result, 0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk); #1;
            if (en_out) pulses++;
        end
        check("t4_no_en_out", pulses, 0);
        check("t4_result_stays", result, 0);
        run0(xa, {xa, xa}, 0, lat);
        check("t4_fresh_latency", lat, 64);
        check("t4_fresh_res0", result[8:0], 252);

        // 5: en_in held high, x_in changed mid-run
        @(negedge clk);
        xa = xv(63, 63, 63, 63);
        x_in = xa; w_in = {xa, xa}; en_in = 1'b1;
        @(posedge clk); #1;
        t1 = -1; t2 = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (n == 10) x_in = '0;
            if (en_out) begin
                if (t1 < 0) begin
                    t1 = n;
                    check("t5_latched_res0", result[8:0], 252);
                end else begin
                    t2 = n;
                    en_in = 1'b0;
                    check("t5_second_res0", result[8:0], 0);
                    break;
                end
            end
        end
        en_in = 1'b0;
        check("t5_first_latency", t1, 64);
        check("t5_period", t2 - t1, 65);
        @(posedge clk); #1;
        check("t5_stop_busy", busy, 0);

        // 6: LFSR mode, approximate but repeatable
        xa = xv(63, 63, 63, 63);
        run1(xa, {xa, xa}, lat);
        check("t6_latency", lat, 64);
        diff = int'(res_l[8:0]) - 252;
        if (diff < 0) diff = -diff;
        check("t6_close_res0", diff <= 16, 1);
        diff = int'(res_l[17:9]) - 252;
        if (diff < 0) diff = -diff;
        check("t6_close_res1", diff <= 16, 1);
        first_l = res_l;
        repeat (3) @(posedge clk);
        run1(xa, {xa, xa}, lat);
        check("t6_repeat", res_l, first_l);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
